// File: rtl/tb_mem_arb_pkg.sv
// Shared types and constants for the testbench RAM port arbiter.
// The optional grant-stall feature is enabled with TB_MEM_ARB_STALL_EN.
package tb_mem_arb_pkg;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_sel_e;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned CONFLICT_CNT_W = 32;

    function automatic logic lfsr_feedback(input logic [15:0] state);
        return ^(state & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/tb_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to inject random grant stalls
// when TB_MEM_ARB_STALL_EN is defined.
module tb_lfsr16
    import tb_mem_arb_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [15:0] lfsr_o
);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_o <= SEED;
        end else begin
            lfsr_o <= {lfsr_o[14:0], lfsr_feedback(lfsr_o)};
        end
    end

endmodule

// File: rtl/tb_mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous testbench RAM between the fetch
// and load/store OBI ports; TB_MEM_ARB_STALL_EN adds LFSR-driven grant stalls.
module tb_mem_port_arbiter
    import tb_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 22,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [15:0] STALL_SEED = 16'hACE1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,

    input  logic                        instr_req_i,
    input  logic [ADDR_WIDTH-1:0]       instr_addr_i,
    output logic                        instr_gnt_o,
    output logic                        instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]       instr_rdata_o,

    input  logic                        data_req_i,
    input  logic [ADDR_WIDTH-1:0]       data_addr_i,
    input  logic                        data_we_i,
    input  logic [DATA_WIDTH/8-1:0]     data_be_i,
    input  logic [DATA_WIDTH-1:0]       data_wdata_i,
    output logic                        data_gnt_o,
    output logic                        data_rvalid_o,
    output logic [DATA_WIDTH-1:0]       data_rdata_o,

    output logic                        ram_en_o,
    output logic [ADDR_WIDTH-1:0]       ram_addr_o,
    output logic                        ram_we_o,
    output logic [DATA_WIDTH/8-1:0]     ram_be_o,
    output logic [DATA_WIDTH-1:0]       ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]       ram_rdata_i,

    output logic [CONFLICT_CNT_W-1:0]   conflict_cnt_o
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    port_sel_e                   last_grant_q;
    port_sel_e                   resp_owner_q;
    logic                        resp_valid_q;
    logic [CONFLICT_CNT_W-1:0]   conflict_cnt_q;
    logic [DATA_WIDTH-1:0]       instr_rdata_q;
    logic [DATA_WIDTH-1:0]       data_rdata_q;
    logic                        stall;
    logic                        conflict;

`ifdef TB_MEM_ARB_STALL_EN
    logic [15:0] lfsr;
    logic [13:0] unused_lfsr_hi;

    tb_lfsr16 #(
        .SEED   (STALL_SEED)
    ) u_lfsr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .lfsr_o (lfsr)
    );

    assign stall          = (lfsr[1:0] == 2'b00);
    assign unused_lfsr_hi = lfsr[15:2];
`else
    logic [15:0] unused_stall_seed;

    assign stall             = 1'b0;
    assign unused_stall_seed = STALL_SEED;
`endif

    assign conflict = instr_req_i & data_req_i;

    // On a conflict the port that did not win last time is served.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        instr_gnt_o = 1'b0;
        data_gnt_o  = 1'b0;
        if (!rst_i && !stall) begin
            if (conflict) begin
                instr_gnt_o = (last_grant_q == PORT_DATA);
                data_gnt_o  = (last_grant_q == PORT_INSTR);
            end else begin
                instr_gnt_o = instr_req_i;
                data_gnt_o  = data_req_i;
            end
        end
    end

    // RAM request mux; all fields are zero while idle.
    always_comb begin
        ram_en_o    = instr_gnt_o | data_gnt_o;
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_wdata_o = '0;
        if (instr_gnt_o) begin
            ram_addr_o = instr_addr_i;
            ram_be_o   = {BE_WIDTH{1'b1}};
        end else if (data_gnt_o) begin
            ram_addr_o  = data_addr_i;
            ram_we_o    = data_we_i;
            ram_be_o    = data_be_i;
            ram_wdata_o = data_wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q   <= PORT_DATA;
            resp_owner_q   <= PORT_INSTR;
            resp_valid_q   <= 1'b0;
            conflict_cnt_q <= '0;
            instr_rdata_q  <= '0;
            data_rdata_q   <= '0;
        end else begin
            if (instr_gnt_o) begin
                last_grant_q <= PORT_INSTR;
            end else if (data_gnt_o) begin
                last_grant_q <= PORT_DATA;
            end

            resp_valid_q <= instr_gnt_o | data_gnt_o;
            if (instr_gnt_o | data_gnt_o) begin
                resp_owner_q <= data_gnt_o ? PORT_DATA : PORT_INSTR;
            end

            if (conflict && (conflict_cnt_q != {CONFLICT_CNT_W{1'b1}})) begin
                conflict_cnt_q <= conflict_cnt_q + 1'b1;
            end

            // Each port keeps showing its last response word between responses.
            if (instr_rvalid_o) begin
                instr_rdata_q <= ram_rdata_i;
            end
            if (data_rvalid_o) begin
                data_rdata_q <= ram_rdata_i;
            end
        end
    end

    assign instr_rvalid_o = resp_valid_q & (resp_owner_q == PORT_INSTR);
    assign data_rvalid_o  = resp_valid_q & (resp_owner_q == PORT_DATA);
    assign instr_rdata_o  = instr_rvalid_o ? ram_rdata_i : instr_rdata_q;
    assign data_rdata_o   = data_rvalid_o  ? ram_rdata_i : data_rdata_q;
    assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: doc/tb_mem_port_arbiter.md
Name: tb_mem_port_arbiter

Overview:
- Shares the single-port testbench RAM between the core instruction-fetch port and the core data port inside the cv32e40p testbench wrapper.
- Both upstream sides speak OBI-style req/gnt/rvalid. The RAM side is a plain synchronous SRAM with 1-cycle read latency.
- Arbitration is round-robin with a bounded 1-cycle wait, and a saturating conflict counter feeds the end-of-test report.

Parameters:
- ADDR_WIDTH, 22, byte-address width presented to the RAM.
- DATA_WIDTH, 32, data width of both ports and the RAM (byte enables are DATA_WIDTH/8 bits).
- STALL_SEED, 16'hACE1, LFSR reset seed; used only with the optional feature.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- instr_req_i  in  1  fetch request
- instr_addr_i  in  ADDR_WIDTH  fetch address
- instr_gnt_o  out  1  fetch grant (combinational)
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  DATA_WIDTH  fetch read data
- data_req_i  in  1  load/store request
- data_addr_i  in  ADDR_WIDTH  load/store address
- data_we_i  in  1  1 = write
- data_be_i  in  DATA_WIDTH/8  byte enables
- data_wdata_i  in  DATA_WIDTH  write data
- data_gnt_o  out  1  load/store grant (combinational)
- data_rvalid_o  out  1  load/store response valid (also asserted for writes)
- data_rdata_o  out  DATA_WIDTH  load read data
- ram_en_o  out  1  RAM access enable
- ram_addr_o  out  ADDR_WIDTH  RAM address
- ram_we_o  out  1  RAM write enable
- ram_be_o  out  DATA_WIDTH/8  RAM byte enables
- ram_wdata_o  out  DATA_WIDTH  RAM write data
- ram_rdata_i  in  DATA_WIDTH  RAM read data, valid 1 cycle after ram_en_o
- conflict_cnt_o  out  32  count of cycles in which both ports requested

Behaviour:
- Reset:
  - While rst_i is high: both gnt outputs 0, ram_en_o 0, both rvalid 0, conflict_cnt_o 0, last_grant = PORT_DATA (so the instruction port wins the first conflict).
  - If rst_i asserts while a response is pending, that response is dropped; no rvalid is issued afterwards.
- Grant (same cycle as req):
  - Only one requester → that requester is granted.
  - Both requesters → the port not in last_grant is granted.
  - last_grant updates on the clock edge after any grant.
  - With at most one grant per cycle, a continuously requesting port waits at most 1 cycle.
- RAM drive:
  - ram_en_o = any grant.
  - ram_addr_o, ram_we_o, ram_be_o and ram_wdata_o are muxed from the granted port.
  - Fetch side: ram_we_o = 0 and ram_be_o = all ones.
  - ram_addr_o, ram_we_o, ram_be_o and ram_wdata_o are 0 when there is no grant.
- Response:
  - A registered 1-bit owner tag plus a valid flag route the response.
  - The granted port's rvalid is asserted exactly 1 cycle after its grant, with rdata = ram_rdata_i.
  - The other port's rdata holds its last value and its rvalid stays 0.
  - Back-to-back grants produce back-to-back rvalids; there is no response buffering beyond 1 entry.
- Counter: conflict_cnt_o increments in every cycle where both req are high (including stalled cycles) and saturates at 32'hFFFF_FFFF.
- Requesters are OBI: a request held without grant must keep its address and data stable. This is not checked by the block.

Optional Feature:
- Macro: TB_MEM_ARB_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11), reset to STALL_SEED, advances every cycle.
  - When lfsr[1:0] == 2'b00, no grant is issued that cycle and last_grant is unchanged.
  - The wait bound becomes unbounded but is statistically 25% extra per cycle.
- Undefined: no LFSR is instantiated and grants are never suppressed.

Decomposition:
- Package tb_mem_arb_pkg:
  - enum port_sel_e {PORT_INSTR = 1'b0, PORT_DATA = 1'b1}
  - LFSR tap mask constant
  - conflict counter width constant (32)
- Sub-module tb_lfsr16 (seeded, free-running), instantiated only under TB_MEM_ARB_STALL_EN.

Test Plan:
- Instruction-only stream, instr_req_i held 4 cycles at addr 0x80, 0x84, 0x88, 0x8C → instr_gnt_o = 1 each cycle; instr_rvalid_o = 1 cycles 2-5 with the preloaded words; conflict_cnt_o = 0.
- Both req high from reset release, held 4 cycles → grants alternate I, D, I, D; each rvalid arrives 1 cycle after its own grant; conflict_cnt_o = 4.
- Data write 0xDEADBEEF with be = 4'b0011 to 0x1000, then data read of 0x1000 (prior content 0) → rdata = 0x0000BEEF; data_rvalid_o is also asserted for the write.
- Reset asserted in the cycle after a data grant → no data_rvalid_o afterwards; all outputs 0 during reset; first grant after release follows the reset state (instruction port wins a conflict).
- Force conflict count to 32'hFFFF_FFFE, then 3 conflict cycles → conflict_cnt_o stays at 32'hFFFF_FFFF.
- With TB_MEM_ARB_STALL_EN and STALL_SEED = 16'hACE1, 1000 cycles of instruction-only requests → grant count equals the count of cycles with lfsr[1:0] != 0 in a golden LFSR model; no rvalid without a prior grant.
